// File: rtl/majority_pkg.sv
// Shared TMR definitions: default voter sizing and the per-bit 2-of-3 majority function.
package majority_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/majority_err_counter.sv
// Saturating disagreement counter; updates 1 cycle after inc/clr; no backpressure, holds at all-ones.
module majority_err_counter
  import majority_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/majority.sv
// Bitwise 2-of-3 voter: x combinational, x_q/flags/counters 1 cycle later.
// No backpressure: inputs are sampled every clock.
module majority
  import majority_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_q,
  output logic             unanimous_q,
  output logic             fault_a_q,
  output logic             fault_b_q,
  output logic             fault_c_q,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  logic fault_a;
  logic fault_b;
  logic fault_c;
  logic unanimous;

  always_comb begin
    x = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x[i] = maj3(a[i], b[i], c[i]);
    end
  end

  // Each bit may have a different dissenter, so several faults can coexist when WIDTH > 1.
  assign fault_a   = |(a ^ x);
  assign fault_b   = |(b ^ x);
  assign fault_c   = |(c ^ x);
  assign unanimous = (a == b) && (b == c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      unanimous_q <= 1'b0;
      fault_a_q   <= 1'b0;
      fault_b_q   <= 1'b0;
      fault_c_q   <= 1'b0;
    end else begin
      x_q         <= x;
      unanimous_q <= unanimous;
      fault_a_q   <= fault_a;
      fault_b_q   <= fault_b;
      fault_c_q   <= fault_c;
    end
  end

  // Counters take the combinational fault so they move on the same edge as the flags.
  majority_err_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (fault_a),
    .cnt   (err_cnt_a)
  );

  majority_err_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (fault_b),
    .cnt   (err_cnt_b)
  );

  majority_err_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (fault_c),
    .cnt   (err_cnt_c)
  );

endmodule

// File: tb/tb_majority.sv
// Scoreboard bench: a 4-bit/3-bit-counter voter and a 1-bit/16-bit-counter voter share stimulus.
module tb_majority;

  logic clk;
  logic rst_n;
  logic clr_cnt;
  logic [3:0] a4, b4, c4;
  logic a1, b1, c1;

  logic [3:0] x4, x_q4;
  logic       un4, fa4, fb4, fc4;
  logic [2:0] ca4, cb4, cc4;
  logic       x1, x_q1;
  logic       un1, fa1, fb1, fc1;
  logic [15:0] ca1, cb1, cc1;

  assign a1 = a4[0];
  assign b1 = b4[0];
  assign c1 = c4[0];

  majority #(.WIDTH(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .clr_cnt(clr_cnt),
    .x(x4), .x_q(x_q4), .unanimous_q(un4),
    .fault_a_q(fa4), .fault_b_q(fb4), .fault_c_q(fc4),
    .err_cnt_a(ca4), .err_cnt_b(cb4), .err_cnt_c(cc4)
  );

  majority #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .clr_cnt(clr_cnt),
    .x(x1), .x_q(x_q1), .unanimous_q(un1),
    .fault_a_q(fa1), .fault_b_q(fb1), .fault_c_q(fc1),
    .err_cnt_a(ca1), .err_cnt_b(cb1), .err_cnt_c(cc1)
  );

  typedef struct {
    int x[2];
    int xq[2];
    int un[2];
    int flt[2][3];
    int cnt[2][3];
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  int   m_cnt[2][3];
  bit   in_rst;
  int   la, lb, lc;
  int   width_k[2] = '{4, 1};
  int   cmax[2]    = '{7, 65535};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  // Majority by counting ones per bit position.
  function automatic int vote(input int w, input int va, input int vb, input int vc);
    int r = 0;
    for (int i = 0; i < w; i++) begin
      if (((va >> i) & 1) + ((vb >> i) & 1) + ((vc >> i) & 1) >= 2) r |= (1 << i);
    end
    return r;
  endfunction

  task automatic model(input bit tick, input bit clr, output exp_t e);
    int in_v[3];
    int mask, xv;
    bit f;
    for (int k = 0; k < 2; k++) begin
      mask = (1 << width_k[k]) - 1;
      in_v[0] = la & mask;
      in_v[1] = lb & mask;
      in_v[2] = lc & mask;
      xv = vote(width_k[k], in_v[0], in_v[1], in_v[2]);
      e.x[k] = xv;
      if (in_rst) begin
        e.xq[k] = 0;
        e.un[k] = 0;
        for (int j = 0; j < 3; j++) begin
          m_cnt[k][j] = 0;
          e.flt[k][j] = 0;
          e.cnt[k][j] = 0;
        end
      end else begin
        e.xq[k] = xv;
        e.un[k] = ((in_v[0] == in_v[1]) && (in_v[1] == in_v[2])) ? 1 : 0;
        for (int j = 0; j < 3; j++) begin
          f = (in_v[j] != xv);
          e.flt[k][j] = f ? 1 : 0;
          if (tick) begin
            if (clr) m_cnt[k][j] = 0;
            else if (f && m_cnt[k][j] < cmax[k]) m_cnt[k][j]++;
          end
          e.cnt[k][j] = m_cnt[k][j];
        end
      end
    end
  endtask

  task automatic step(input int va, input int vb, input int vc, input bit clr, input bit rel);
    exp_t e;
    @(negedge clk);
    if (rel) begin
      rst_n  = 1'b1;
      in_rst = 1'b0;
    end
    la = va; lb = vb; lc = vc;
    a4 = 4'(va);
    b4 = 4'(vb);
    c4 = 4'(vc);
    clr_cnt = clr;
    model(1'b1, clr, e);
    exp_q.push_back(e);
  endtask

  // Reset dropped between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    exp_t e;
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    in_rst = 1'b1;
    model(1'b0, 1'b0, e);
    exp_q.push_back(e);
    #1;
    -> sample_ev;
  endtask

  always begin
    @(posedge clk);
    #1;
    -> sample_ev;
  end

  initial begin : monitor
    exp_t e;
    int ax[2], axq[2], aun[2], af[2][3], ac[2][3];
    forever begin
      @(sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ax[0]  = int'(x4);   ax[1]  = int'(x1);
        axq[0] = int'(x_q4); axq[1] = int'(x_q1);
        aun[0] = int'(un4);  aun[1] = int'(un1);
        af[0][0] = int'(fa4); af[0][1] = int'(fb4); af[0][2] = int'(fc4);
        af[1][0] = int'(fa1); af[1][1] = int'(fb1); af[1][2] = int'(fc1);
        ac[0][0] = int'(ca4); ac[0][1] = int'(cb4); ac[0][2] = int'(cc4);
        ac[1][0] = int'(ca1); ac[1][1] = int'(cb1); ac[1][2] = int'(cc1);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("dut%0d x", k), ax[k], e.x[k]);
          chk($sformatf("dut%0d x_q", k), axq[k], e.xq[k]);
          chk($sformatf("dut%0d unanimous_q", k), aun[k], e.un[k]);
          for (int j = 0; j < 3; j++) begin
            chk($sformatf("dut%0d fault_%0d_q", k, j), af[k][j], e.flt[k][j]);
            chk($sformatf("dut%0d err_cnt_%0d", k, j), ac[k][j], e.cnt[k][j]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : driver
    int va, vb, vc;
    rst_n = 1'b0; in_rst = 1'b1;
    a4 = '0; b4 = '0; c4 = '0; clr_cnt = 1'b0;
    la = 0; lb = 0; lc = 0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;

    step(0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);

    // Truth table walk, replicated across all bits.
    for (int v = 0; v < 8; v++) begin
      va = v[2] ? 15 : 0;
      vb = v[1] ? 15 : 0;
      vc = v[0] ? 15 : 0;
      step(va, vb, vc, 1'b0, v == 0);
    end

    step(0, 0, 0, 1'b1, 1'b0);
    repeat (5) step(15, 0, 0, 1'b0, 1'b0);
    repeat (5) step(15, 0, 0, 1'b0, 1'b0);
    step(15, 0, 0, 1'b1, 1'b0);
    step(15, 0, 0, 1'b0, 1'b0);

    repeat (3) step(12, 10, 9, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    step(15, 15, 15, 1'b0, 1'b0);

    repeat (200) begin
      va = int'($urandom_range(0, 15));
      vb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : va;
      vc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : va;
      if ($urandom_range(0, 1) == 1) begin
        va = int'($urandom_range(0, 15));
      end
      step(va, vb, vc, $urandom_range(0, 15) == 0, 1'b0);
    end

    repeat (3) step(0, 15, 15, 1'b0, 1'b0);
    step(15, 15, 15, 1'b0, 1'b0);
    reset_pulse();
    step(15, 15, 15, 1'b0, 1'b0);
    step(15, 15, 15, 1'b0, 1'b1);
    step(1, 2, 4, 1'b0, 1'b0);
    step(6, 6, 6, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/majority.md
Name: majority

Overview:
- Bitwise 2-of-3 majority voter for triple-redundant signals.
- Combinational voted output, plus a registered copy of the vote.
- Per-input disagreement flags and saturating disagreement counters, used for fault monitoring.
- Sits between three redundant sources and downstream logic that consumes the voted value.

Parameters:
- WIDTH, 1, bit width of each voted input and of the voted output; the vote is independent per bit.
- CNT_W, 16, width of each per-input disagreement counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  redundant input copy A.
- b  input  WIDTH  redundant input copy B.
- c  input  WIDTH  redundant input copy C.
- clr_cnt  input  1  synchronous clear of all three counters.
- x  output  WIDTH  combinational majority, (a&b)|(b&c)|(a&c) per bit.
- x_q  output  WIDTH  x registered, one cycle latency.
- unanimous_q  output  1  registered; 1 when a==b==c on all bits.
- fault_a_q  output  1  registered; 1 when any bit of a differs from x.
- fault_b_q  output  1  registered; 1 when any bit of b differs from x.
- fault_c_q  output  1  registered; 1 when any bit of c differs from x.
- err_cnt_a  output  CNT_W  saturating count of cycles with fault on a.
- err_cnt_b  output  CNT_W  saturating count of cycles with fault on b.
- err_cnt_c  output  CNT_W  saturating count of cycles with fault on c.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- x:
  - Purely combinational, no clock or reset dependence.
  - Settles within the same delta cycle as any input change.
  - 3-input truth table for (a,b,c) = 000..111 gives x = 0,0,0,1,0,1,1,1.
- Reset: while rst_n=0, x_q, unanimous_q, all fault_*_q and all err_cnt_* are 0.
  - Reset asserted mid-operation clears these immediately, not on a clock edge.
  - x keeps tracking the inputs during reset.
- Per rising edge with rst_n=1:
  - x_q <= x.
  - unanimous_q <= (a==b) && (b==c).
  - fault_a_q <= |(a ^ x); likewise for b and c.
- Fault flags:
  - For WIDTH=1 at most one fault flag is set in a cycle.
  - For WIDTH>1 several fault flags may be set together, because different bits can have different dissenters.
  - unanimous_q=1 implies all fault flags are 0.
- Counters, per rising edge:
  - If clr_cnt=1, the counter goes to 0. clr_cnt has priority over an increment in the same cycle.
  - Else if that input's current combinational fault condition is true and the counter is below all-ones, increment by 1.
  - At all-ones the counter holds (saturates, no wrap).
  - Counter increments are based on the combinational fault condition, not on the registered flag. Counter and flag therefore update on the same edge.
- First edge after reset release:
  - Behaves as a normal cycle.
  - No special start-up state; no FSM.

Decomposition:
- majority_pkg holds:
  - default WIDTH and CNT_W localparams;
  - a function maj3(a,b,c) returning the bitwise majority, shared with other TMR blocks.
- One sub-module, majority_err_counter:
  - inputs clk, rst_n, clr, inc;
  - CNT_W saturating counter;
  - instantiated three times (A, B, C).

Test Plan:
- WIDTH=1, step {a,b,c} through 000..111 at 10 ns intervals -> x = 0,0,0,1,0,1,1,1 combinationally; x_q shows the same sequence one clock later.
- {a,b,c}=100 for 5 clocks after reset -> x=0, fault_a_q=1, fault_b_q=fault_c_q=0, unanimous_q=0, err_cnt_a=5, other counters 0.
- WIDTH=4, a=4'b1100, b=4'b1010, c=4'b1001 -> x=4'b1000; fault_a_q, fault_b_q and fault_c_q all 1; each counter increments by 1 per cycle.
- CNT_W=3, hold a as the dissenter for 10 clocks -> err_cnt_a goes 1..7 then holds at 7. clr_cnt=1 on a cycle with the fault still present -> err_cnt_a=0 after that edge.
- Drive {a,b,c}=111 with counters nonzero, then pulse rst_n low between clock edges -> x_q, flags and counters go to 0 immediately; x stays 1 throughout.
- {a,b,c}=000 and 111 -> unanimous_q=1, no fault flags set, counters unchanged.
